// File: rtl/ula_arb_pkg.sv
// ula_arb_pkg: shared types, default sizes and helpers for the ULA arbiter.
package ula_arb_pkg;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W = 8;
    localparam int CNT_W = 16;
    function automatic int id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/ula_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick, first set req bit above ptr_i (with wrap).
module rr_picker import ula_arb_pkg::*; #(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [id_w(NUM_REQ)-1:0]  ptr_i,
    output logic [NUM_REQ-1:0]        win_o,
    output logic [id_w(NUM_REQ)-1:0]  idx_o,
    output logic                      any_o
);
    localparam int IW = id_w(NUM_REQ);
    // Scan from farthest to nearest so the nearest set bit is written last.
    always_comb begin
        idx_o = '0;
        for (int i = NUM_REQ; i >= 1; i--)
            if (req_i[IW'((int'(ptr_i) + i) % NUM_REQ)]) idx_o = IW'((int'(ptr_i) + i) % NUM_REQ);
    end
    assign any_o = |req_i;
    assign win_o = any_o ? NUM_REQ'(1) << idx_o : '0;
endmodule

// File: rtl/ula_arbiter.sv
// ula_arbiter: round-robin sharing of one ULA datapath among NUM_REQ cores.
// Define ULA_ARBITER_STATS_EN to add per-core saturating grant counters (grant_cnt).
module ula_arbiter import ula_arb_pkg::*; #(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ULA_LAT = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_opcode,
    input  logic [NUM_REQ*DATA_W-1:0] req_op1,
    input  logic [NUM_REQ*DATA_W-1:0] req_op2,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      rsp_valid,
    output logic [id_w(NUM_REQ)-1:0]  rsp_id,
    output logic [DATA_W-1:0]         rsp_result,
    output logic [DATA_W-1:0]         rsp_flags,
    output logic [DATA_W-1:0]         ula_opcode,
    output logic [DATA_W-1:0]         ula_operand1,
    output logic [DATA_W-1:0]         ula_operand2,
    input  logic [DATA_W-1:0]         ula_result,
    input  logic [DATA_W-1:0]         ula_flags,
    output logic                      busy
`ifdef ULA_ARBITER_STATS_EN
    ,output logic [NUM_REQ*CNT_W-1:0] grant_cnt
`endif
);
    localparam int IW = id_w(NUM_REQ);
    localparam int CW = $clog2(ULA_LAT + 1);
    state_t state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d, win_q, win_d, rsp_id_q, rsp_id_d, pick_idx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d, pick_win;
    logic rv_q, rv_d, pick_any;
    logic [DATA_W-1:0] res_q, res_d, flg_q, flg_d, opc_q, opc_d, op1_q, op1_d, op2_q, op2_d;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i(req), .ptr_i(ptr_q), .win_o(pick_win), .idx_o(pick_idx), .any_o(pick_any)
    );

    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        win_d = win_q;
        cnt_d = cnt_q;
        gnt_d = '0;
        rv_d = 1'b0;
        rsp_id_d = rsp_id_q;
        res_d = res_q;
        flg_d = flg_q;
        opc_d = opc_q;
        op1_d = op1_q;
        op2_d = op2_q;
        case (state_q)
            IDLE: begin
                gnt_d = pick_win;
                win_d = pick_any ? pick_idx : win_q;
                opc_d = pick_any ? req_opcode[pick_idx*DATA_W +: DATA_W] : '0;
                op1_d = pick_any ? req_op1[pick_idx*DATA_W +: DATA_W] : '0;
                op2_d = pick_any ? req_op2[pick_idx*DATA_W +: DATA_W] : '0;
                cnt_d = '0;
                state_d = pick_any ? EXEC : IDLE;
            end
            EXEC: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ULA_LAT - 1)) begin
                    res_d = ula_result;
                    flg_d = ula_flags;
                    rsp_id_d = win_q;
                    rv_d = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                ptr_d = win_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q <= IW'(NUM_REQ - 1);
            win_q <= '0;
            cnt_q <= '0;
            gnt_q <= '0;
            rv_q <= 1'b0;
            rsp_id_q <= '0;
            res_q <= '0;
            flg_q <= '0;
            opc_q <= '0;
            op1_q <= '0;
            op2_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            win_q <= win_d;
            cnt_q <= cnt_d;
            gnt_q <= gnt_d;
            rv_q <= rv_d;
            rsp_id_q <= rsp_id_d;
            res_q <= res_d;
            flg_q <= flg_d;
            opc_q <= opc_d;
            op1_q <= op1_d;
            op2_q <= op2_d;
        end
    end

    assign gnt = gnt_q;
    assign rsp_valid = rv_q;
    assign rsp_id = rsp_id_q;
    assign rsp_result = res_q;
    assign rsp_flags = flg_q;
    assign ula_opcode = opc_q;
    assign ula_operand1 = op1_q;
    assign ula_operand2 = op2_q;
    assign busy = state_q != IDLE;

`ifdef ULA_ARBITER_STATS_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] gcnt_q;
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++)
            if (!reset) gcnt_q[i] <= '0;
            else if (gnt_q[i] && gcnt_q[i] != '1) gcnt_q[i] <= gcnt_q[i] + CNT_W'(1);
    end
    assign grant_cnt = gcnt_q;
`endif
endmodule
